// File: rtl/log_flaf_pkg.sv
// Shared definitions for the logarithmic FLAF weight-update engine:
// FSM states, log/linear format constants, saturation limits and the antilog table.
package log_flaf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_WR,
        ST_DONE
    } state_t;

    localparam int QP        = 12;
    localparam int LOG_WIDTH = 17;

    localparam logic [15:0] W_MAX = 16'h7FFF;
    localparam logic [15:0] W_MIN = 16'h8000;
    localparam logic [15:0] D_MAX = 16'h7FFF;

    // round(4096 * 2^(i/64)), indexed by the top six fraction bits
    localparam logic [12:0] ANTILOG_TABLE [64] = '{
        13'd4096, 13'd4141, 13'd4186, 13'd4231, 13'd4277, 13'd4324, 13'd4371, 13'd4419,
        13'd4467, 13'd4515, 13'd4565, 13'd4614, 13'd4664, 13'd4715, 13'd4767, 13'd4819,
        13'd4871, 13'd4924, 13'd4978, 13'd5032, 13'd5087, 13'd5142, 13'd5198, 13'd5255,
        13'd5312, 13'd5370, 13'd5428, 13'd5487, 13'd5547, 13'd5607, 13'd5668, 13'd5730,
        13'd5793, 13'd5856, 13'd5919, 13'd5984, 13'd6049, 13'd6115, 13'd6182, 13'd6249,
        13'd6317, 13'd6386, 13'd6455, 13'd6526, 13'd6597, 13'd6668, 13'd6741, 13'd6814,
        13'd6889, 13'd6964, 13'd7039, 13'd7116, 13'd7194, 13'd7272, 13'd7351, 13'd7431,
        13'd7512, 13'd7594, 13'd7677, 13'd7760, 13'd7845, 13'd7930, 13'd8016, 13'd8104
    };

endpackage

// File: rtl/antilog_lut.sv
// Combinational log fraction to Q12 mantissa in [4096, 8191].
// ANTILOG_LUT_EN selects the 64-entry table; otherwise Mitchell's 1+f approximation.
module antilog_lut
    import log_flaf_pkg::*;
(
    input  logic [11:0] frac,
    output logic [12:0] mant
);

`ifdef ANTILOG_LUT_EN
    logic unused_frac_low;

    assign unused_frac_low = ^frac[5:0];
    assign mant            = ANTILOG_TABLE[frac[11:6]];
`else
    assign mant = {1'b1, frac};
`endif

endmodule

// File: rtl/log_weight_update.sv
// Sequential log-domain LMS weight updater: one adder, one shifter and an antilog
// stage shared across all taps. Mantissa source selected by ANTILOG_LUT_EN.
module log_weight_update
    import log_flaf_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int QP        = 12,
    parameter int LOG_WIDTH = 17,
    parameter int TAPS      = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [LOG_WIDTH-1:0] log_error,
    input  logic                 log_error_sign,
    input  logic                 log_error_valid,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    tap_addr,
    input  logic [LOG_WIDTH-1:0] log_x,
    input  logic                 log_x_sign,
    input  logic                 log_x_valid,
    input  logic [WIDTH-1:0]     w_rd_data,
    output logic                 w_wr_en,
    output logic [WIDTH-1:0]     w_wr_data
);

    localparam int KW = LOG_WIDTH + 1 - QP;
    localparam logic signed [KW-1:0] K_SAT = KW'(3);
    localparam logic [KW-1:0]        K_ZERO = KW'(QP + 1);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     tap_q, tap_d;
    logic [LOG_WIDTH-1:0]  err_q, err_d;
    logic                  err_sign_q, err_sign_d;
    logic                  err_valid_q, err_valid_d;
    logic [WIDTH-1:0]      w_new_q, w_new_d;
    logic                  upd_q, upd_d;

    logic signed [LOG_WIDTH:0] log_sum;
    logic signed [KW-1:0]      shift_k;
    logic [KW-1:0]             shift_r;
    logic [QP-1:0]             frac;
    logic [12:0]               mant;
    logic [WIDTH-1:0]          mag;
    logic signed [WIDTH:0]     delta;
    logic signed [WIDTH:0]     upd_sum;
    logic [WIDTH-1:0]          w_sat;

    antilog_lut u_antilog (
        .frac (frac),
        .mant (mant)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            err_q       <= '0;
            err_sign_q  <= 1'b0;
            err_valid_q <= 1'b0;
            w_new_q     <= '0;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            err_q       <= err_d;
            err_sign_q  <= err_sign_d;
            err_valid_q <= err_valid_d;
            w_new_q     <= w_new_d;
            upd_q       <= upd_d;
        end
    end

    // Log-domain product, antilog, then signed saturating accumulate.
    always_comb begin
        log_sum = $signed({err_q[LOG_WIDTH-1], err_q}) + $signed({log_x[LOG_WIDTH-1], log_x});
        shift_k = log_sum[LOG_WIDTH:QP];
        frac    = log_sum[QP-1:0];
        shift_r = $unsigned(-shift_k);
        mag     = '0;
        if (!shift_k[KW-1]) begin
            if (shift_k >= K_SAT) begin
                mag = D_MAX;
            end else begin
                mag = WIDTH'(mant) << $unsigned(shift_k);
            end
        end else if (shift_r < K_ZERO) begin
            mag = WIDTH'(mant) >> shift_r;
        end
        delta = $signed({1'b0, mag});
        if (err_sign_q ^ log_x_sign) begin
            delta = -delta;
        end
        upd_sum = $signed({w_rd_data[WIDTH-1], w_rd_data}) + delta;
        w_sat   = upd_sum[WIDTH-1:0];
        if (upd_sum[WIDTH] != upd_sum[WIDTH-1]) begin
            w_sat = upd_sum[WIDTH] ? W_MIN : W_MAX;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        err_d       = err_q;
        err_sign_d  = err_sign_q;
        err_valid_d = err_valid_q;
        w_new_d     = w_new_q;
        upd_d       = upd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d       = log_error;
                    err_sign_d  = log_error_sign;
                    err_valid_d = log_error_valid;
                    tap_d       = '0;
                    state_d     = ST_RD;
                end
            end
            ST_RD: state_d = ST_CALC;
            ST_CALC: begin
                w_new_d = w_sat;
                upd_d   = err_valid_q & log_x_valid;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (tap_q == ADDR_W'(TAPS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign tap_addr  = tap_q;
    assign w_wr_en   = (state_q == ST_WR) & upd_q;
    assign w_wr_data = w_new_q;

endmodule

// File: tb/tb_log_weight_update.sv
// Directed self-checking bench for log_weight_update with a registered
// expansion/weight memory model answering one cycle after tap_addr.
module tb_log_weight_update;

    localparam int TAPS = 8;
    localparam int LAST = 3 * TAPS;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [16:0] log_error;
    logic        log_error_sign;
    logic        log_error_valid;
    logic        busy;
    logic        done;
    logic [2:0]  tap_addr;
    logic [16:0] log_x;
    logic        log_x_sign;
    logic        log_x_valid;
    logic [15:0] w_rd_data;
    logic        w_wr_en;
    logic [15:0] w_wr_data;

    logic [15:0] w_init [TAPS];
    logic [16:0] lx_init [TAPS];
    logic        lxs_init [TAPS];
    logic        lxv_init [TAPS];
    logic [15:0] exp_data [TAPS];
    logic        exp_en [TAPS];

    int tests = 0;
    int fails = 0;

    log_weight_update dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .log_error       (log_error),
        .log_error_sign  (log_error_sign),
        .log_error_valid (log_error_valid),
        .busy            (busy),
        .done            (done),
        .tap_addr        (tap_addr),
        .log_x           (log_x),
        .log_x_sign      (log_x_sign),
        .log_x_valid     (log_x_valid),
        .w_rd_data       (w_rd_data),
        .w_wr_en         (w_wr_en),
        .w_wr_data       (w_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        log_x       <= lx_init[tap_addr];
        log_x_sign  <= lxs_init[tap_addr];
        log_x_valid <= lxv_init[tap_addr];
        w_rd_data   <= w_init[tap_addr];
    end

    task automatic set_uniform(input logic [15:0] w, input logic [16:0] lx, input logic lxs,
                               input logic [15:0] expd);
        for (int i = 0; i < TAPS; i++) begin
            w_init[i]   = w;
            lx_init[i]  = lx;
            lxs_init[i] = lxs;
            lxv_init[i] = 1'b1;
            exp_data[i] = expd;
            exp_en[i]   = 1'b1;
        end
    endtask

    task automatic set_error(input logic [16:0] e, input logic s, input logic v);
        log_error       = e;
        log_error_sign  = s;
        log_error_valid = v;
    endtask

    // One full pass; poke_cycle pulses start with corrupted error inputs for one cycle.
    task automatic run_pass(input string name, input int poke_cycle);
        logic [16:0] sv_e;
        logic        sv_s, sv_v, exp_wr;
        int          tap;
        sv_e = log_error;
        sv_s = log_error_sign;
        sv_v = log_error_valid;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= LAST + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            tap    = (cyc - 1) / 3;
            exp_wr = (cyc % 3 == 0) && (cyc <= LAST) && exp_en[tap];
            tests++;
            if (w_wr_en !== exp_wr) begin
                fails++;
                $display("[TB] FAIL %s wr_en cycle %0d: got %b want %b", name, cyc, w_wr_en, exp_wr);
            end
            if (exp_wr) begin
                tests++;
                if (w_wr_data !== exp_data[tap]) begin
                    fails++;
                    $display("[TB] FAIL %s wr_data tap %0d: got %h want %h", name, tap,
                             w_wr_data, exp_data[tap]);
                end
            end
            if (cyc <= LAST) begin
                tests++;
                if (tap_addr !== 3'(tap)) begin
                    fails++;
                    $display("[TB] FAIL %s tap_addr cycle %0d: got %0d want %0d", name, cyc,
                             tap_addr, tap);
                end
            end
            tests++;
            if (busy !== (cyc <= LAST + 1) || done !== (cyc == LAST + 1)) begin
                fails++;
                $display("[TB] FAIL %s busy/done cycle %0d: got %b/%b", name, cyc, busy, done);
            end
            if (cyc == poke_cycle) begin
                start = 1'b1;
                set_error(~sv_e, ~sv_s, ~sv_v);
            end else if (cyc == poke_cycle + 1) begin
                start = 1'b0;
                set_error(sv_e, sv_s, sv_v);
            end
        end
    endtask

    task automatic test_reset;
        rstn  = 1'b0;
        start = 1'b0;
        set_error(17'h0, 1'b0, 1'b0);
        set_uniform(16'd0, 17'h0, 1'b0, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || w_wr_en !== 1'b0 || w_wr_data !== 16'h0 ||
            tap_addr !== 3'd0) begin
            fails++;
            $display("[TB] FAIL reset: busy %b done %b wr_en %b data %h addr %0d, want all 0",
                     busy, done, w_wr_en, w_wr_data, tap_addr);
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic;
        set_error(17'h00000, 1'b0, 1'b1);
        set_uniform(16'd1000, 17'h00000, 1'b0, 16'd5096);
        run_pass("basic", -5);
    endtask

    task automatic test_negative;
        set_error(17'h1D000, 1'b1, 1'b1);
        set_uniform(16'd0, 17'h01000, 1'b0, 16'hFC00);
        for (int i = 0; i < TAPS; i++) begin
            w_init[i]   = 16'(i * 100);
            exp_data[i] = 16'(i * 100 - 1024);
        end
        run_pass("negative", -5);
    endtask

    task automatic test_saturation;
        set_error(17'h03000, 1'b0, 1'b1);
        set_uniform(16'd30000, 17'h00000, 1'b0, 16'h7FFF);
        run_pass("sat_pos", -5);
        set_error(17'h03000, 1'b1, 1'b1);
        set_uniform(16'(-32000), 17'h00000, 1'b0, 16'h8000);
        run_pass("sat_neg", -5);
    endtask

    task automatic test_invalid;
        set_error(17'h00000, 1'b0, 1'b0);
        set_uniform(16'd1000, 17'h00000, 1'b0, 16'd5096);
        for (int i = 0; i < TAPS; i++) exp_en[i] = 1'b0;
        run_pass("err_invalid", -5);
        set_error(17'h00000, 1'b0, 1'b1);
        set_uniform(16'd1000, 17'h00000, 1'b0, 16'd5096);
        lxv_init[2] = 1'b0;
        exp_en[2]   = 1'b0;
        run_pass("tap2_invalid", -5);
    endtask

    task automatic test_mantissa;
        set_error(17'h00800, 1'b0, 1'b1);
`ifdef ANTILOG_LUT_EN
        set_uniform(16'd0, 17'h00000, 1'b0, 16'd5793);
`else
        set_uniform(16'd0, 17'h00000, 1'b0, 16'd6144);
`endif
        run_pass("mantissa", -5);
    endtask

    task automatic test_start_ignored;
        set_error(17'h00000, 1'b0, 1'b1);
        set_uniform(16'd1000, 17'h00000, 1'b0, 16'd5096);
        run_pass("start_mid", 5);
        run_pass("start_done", LAST + 1);
    endtask

    task automatic test_reset_mid;
        set_error(17'h00000, 1'b0, 1'b1);
        set_uniform(16'd1000, 17'h00000, 1'b0, 16'd5096);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rstn = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || w_wr_en !== 1'b0 || tap_addr !== 3'd0 || w_wr_data !== 16'h0) begin
            fails++;
            $display("[TB] FAIL reset_mid: busy %b wr_en %b addr %0d data %h, want 0",
                     busy, w_wr_en, tap_addr, w_wr_data);
        end
        rstn = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            tests++;
            if (w_wr_en !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_mid_quiet %0d: wr_en %b busy %b, want 0", cyc,
                         w_wr_en, busy);
            end
        end
        run_pass("after_reset", -5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_invalid();
        test_mantissa();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
